// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Iterative signed divider producing quotient and remainder for the ALU
//   result selector. One restoring shift-subtract step per clock on operand
//   magnitudes, followed by a sign fix-up step and a single-cycle done pulse.
//   Results hold stable until the next accepted start.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        asynchronous, active-high reset
//   i_start      request; accepted only in IDLE
//   i_dividend   signed dividend, sampled on accept
//   i_divisor    signed divisor, sampled on accept
//   o_quotient   signed quotient, truncated toward zero
//   o_remainder  signed remainder, sign follows the dividend
//   o_busy       high from the cycle after accept until done
//   o_done       single-cycle pulse when results are valid
//   o_div_zero   set with done when divisor was zero; held until next result
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   r_absDivisor;
  logic [WIDTH-1:0] r_quo;
  logic             r_dividendNeg;
  logic             r_divisorNeg;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_divZero;

  logic [WIDTH-1:0] w_absDividend;
  logic [WIDTH-1:0] w_absDivisorIn;
  logic [WIDTH+1:0] w_trial;
  logic             w_trialNeg;

  // The magnitude of the most negative value, taken as an unsigned W-bit
  // number, is still exact (2^(WIDTH-1)), so plain negation is enough here.
  assign w_absDividend  = i_dividend[WIDTH-1] ? (-i_dividend) : i_dividend;
  assign w_absDivisorIn = i_divisor[WIDTH-1]  ? (-i_divisor)  : i_divisor;

  // Trial subtraction of the shifted partial remainder. One extra bit on top
  // of the (WIDTH+1)-bit accumulator carries the sign of the difference.
  assign w_trial    = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_absDivisor};
  assign w_trialNeg = w_trial[WIDTH+1];

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and status outputs. Start is only looked at in IDLE, so a
  // request during CALC, FIX or DONE is dropped rather than queued.
  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = CALC;
        end
      end
      CALC: begin
        o_busy = 1'b1;
        if (r_count == '0) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        o_busy      = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath. The quotient register starts out holding the dividend
  // magnitude and is shifted into the remainder accumulator one bit per
  // step while quotient bits fill in from the bottom.
  // A zero divisor needs no special handling during CALC: every trial
  // succeeds, leaving the dividend magnitude in the accumulator, so only
  // the quotient is forced in FIX.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count       <= '0;
      r_rem         <= '0;
      r_absDivisor  <= '0;
      r_quo         <= '0;
      r_dividendNeg <= 1'b0;
      r_divisorNeg  <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_divZero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_quo         <= w_absDividend;
            r_absDivisor  <= {1'b0, w_absDivisorIn};
            r_rem         <= '0;
            r_dividendNeg <= i_dividend[WIDTH-1];
            r_divisorNeg  <= i_divisor[WIDTH-1];
            r_count       <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          r_quo <= {r_quo[WIDTH-2:0], ~w_trialNeg};
          r_rem <= w_trialNeg ? {r_rem[WIDTH-1:0], r_quo[WIDTH-1]} : w_trial[WIDTH:0];
          if (r_count != '0) begin
            r_count <= r_count - CW'(1);
          end
        end
        FIX: begin
          if (r_absDivisor == '0) begin
            r_quotient <= '1;
            r_divZero  <= 1'b1;
          end else begin
            r_quotient <= (r_dividendNeg ^ r_divisorNeg) ? (-r_quo) : r_quo;
            r_divZero  <= 1'b0;
          end
          r_remainder <= r_dividendNeg ? (-r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
  assign o_div_zero  = r_divZero;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (WIDTH=16). Expected quotient and
//   remainder come from plain integer division in refDiv; timing
//   expectations come from the operation's documented latency.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             divZero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_busy      (busy),
    .o_done      (done),
    .o_div_zero  (divZero)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: signed division truncating toward zero, remainder taking the
  // dividend's sign; zero divisor yields all-ones and the dividend itself.
  function automatic void refDiv(input logic signed [WIDTH-1:0] a,
                                 input logic signed [WIDTH-1:0] b,
                                 output logic [WIDTH-1:0] q,
                                 output logic [WIDTH-1:0] r,
                                 output logic dz);
    int ai;
    int bi;
    int qi;
    int ri;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q  = qi[WIDTH-1:0];
      r  = ri[WIDTH-1:0];
      dz = 1'b0;
    end
  endfunction

  // Runs one division: pulses start, scrambles operands and re-raises start
  // while busy (both must be ignored), then checks latency, busy length,
  // results and that done lasts exactly one cycle.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input string tag);
    logic [WIDTH-1:0] expQ;
    logic [WIDTH-1:0] expR;
    logic             expDz;
    int               edges;
    int               busyCycles;
    bit               seen;
    refDiv(a, b, expQ, expR, expDz);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start      = 1'b0;
    dividend   = 16'($urandom);
    divisor    = 16'($urandom);
    edges      = 1;
    busyCycles = 0;
    seen       = 1'b0;
    while (!seen && edges < 40) begin
      if (busy) busyCycles++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (edges == 5) start = 1'b1;
        @(posedge clk);
        #1;
        edges++;
      end
    end
    start = 1'b0;
    checkOutput({tag, " done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, " latency"}, edges, 32'd18);
    checkOutput({tag, " busy_cycles"}, busyCycles, 32'd17);
    checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, " quotient"}, 32'(quotient), 32'(expQ));
    checkOutput({tag, " remainder"}, 32'(remainder), 32'(expR));
    checkOutput({tag, " div_zero"}, 32'(divZero), 32'(expDz));
    @(posedge clk);
    #1;
    checkOutput({tag, " done_pulse_end"}, 32'(done), 32'd0);
    checkOutput({tag, " quotient_hold"}, 32'(quotient), 32'(expQ));
  endtask

  initial begin
    logic [WIDTH-1:0] expQ;
    logic [WIDTH-1:0] expR;
    logic             expDz;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int               edges;
    int               donePulses;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset quotient", 32'(quotient), 32'd0);
    checkOutput("reset remainder", 32'(remainder), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset div_zero", 32'(divZero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic 100/7");
    applyStimulus(16'd100, 16'd7, "100/7");
    checkOutput("100/7 const quotient", 32'(quotient), 32'd14);
    checkOutput("100/7 const remainder", 32'(remainder), 32'd2);

    $display("[TB] reset during CALC");
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset quotient", 32'(quotient), 32'd0);
    checkOutput("midreset remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    donePulses = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) donePulses++;
    end
    checkOutput("midreset no_done", donePulses, 32'd0);
    checkOutput("midreset idle", 32'(busy), 32'd0);

    $display("[TB] sign matrix");
    applyStimulus(-16'sd100, 16'sd7, "-100/7");
    applyStimulus(16'sd100, -16'sd7, "100/-7");
    applyStimulus(-16'sd100, -16'sd7, "-100/-7");
    checkOutput("-100/-7 const quotient", 32'(quotient), 32'd14);
    checkOutput("-100/-7 const remainder", 32'(remainder), 32'h0000FFFE);
    applyStimulus(16'd0, 16'd5, "0/5");

    $display("[TB] divide by zero");
    applyStimulus(16'd1234, 16'd0, "1234/0");
    checkOutput("1234/0 const quotient", 32'(quotient), 32'h0000FFFF);
    applyStimulus(16'd10, 16'd3, "10/3");
    applyStimulus(16'h8000, 16'd0, "min/0");

    $display("[TB] edge cases");
    applyStimulus(16'h8000, 16'hFFFF, "min/-1");
    checkOutput("min/-1 const quotient", 32'(quotient), 32'h00008000);
    applyStimulus(16'h8000, 16'd1, "min/1");
    applyStimulus(16'd32767, 16'd32767, "max/max");
    applyStimulus(16'h8000, 16'h8000, "min/min");
    applyStimulus(16'd5, 16'd32767, "small/max");

    // With start held high, a new operation is accepted in the IDLE cycle
    // that follows each DONE cycle, so done pulses are WIDTH+3 edges apart.
    $display("[TB] start held high");
    @(negedge clk);
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 16'd7;
    @(posedge clk);
    #1;
    dividend = 16'd50;
    divisor  = 16'd5;
    edges    = 1;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("held first latency", edges, 32'd18);
    checkOutput("held first quotient", 32'(quotient), 32'd14);
    checkOutput("held first remainder", 32'(remainder), 32'd2);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 60);
    start = 1'b0;
    refDiv(16'd50, 16'd5, expQ, expR, expDz);
    checkOutput("held interval", edges, 32'd19);
    checkOutput("held second quotient", 32'(quotient), 32'(expQ));
    checkOutput("held second remainder", 32'(remainder), 32'(expR));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held stops", 32'(busy), 32'd0);

    $display("[TB] random operands");
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      case (i % 4)
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 20));
        2:       rb = -16'($urandom_range(1, 300));
        default: rb = 16'($urandom);
      endcase
      applyStimulus(ra, rb, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
